// File: rtl/down_count_monitor.sv
// rtl/down_count_monitor.sv - sequencing monitor for an upstream down counter
// Locks onto a decrementing count, flags terminal count and wraps, latches faults.
module down_count_monitor #(
   parameter int WIDTH    = 3,
   parameter int LOCK_LEN = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] q_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             tc_pulse,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] bad_val
);

   typedef enum logic [1:0] {S_INIT, S_LOCKING, S_LOCKED, S_FAULT} state_t;

   localparam logic [WIDTH-1:0] Q_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_LEN);

   state_t           state;
   logic [WIDTH-1:0] q_prev;
   logic [3:0]       lock_run;
   logic [WIDTH-1:0] expected;
   logic             good;

   // A stalled count (q_in == q_prev) can never match expected, so it is a bad step.
   assign expected = q_prev - WIDTH'(1);
   assign good     = (q_in == expected);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_INIT;
         q_prev   <= '0;
         lock_run <= '0;
         locked   <= 1'b0;
         tc_pulse <= 1'b0;
         wrap_cnt <= '0;
         err      <= 1'b0;
         err_cnt  <= '0;
         bad_val  <= '0;
      end else begin
         tc_pulse <= 1'b0;
         if (en)
            q_prev <= q_in;

         // clr_err wins over any step sampled on the same edge.
         if (clr_err) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            bad_val  <= '0;
            lock_run <= '0;
            if (state != S_INIT) begin
               state  <= S_LOCKING;
               locked <= 1'b0;
            end
         end else if (en) begin
            case (state)
               S_INIT: begin
                  state    <= S_LOCKING;
                  lock_run <= '0;
               end
               S_LOCKING: begin
                  if (good) begin
                     lock_run <= lock_run + 4'd1;
                     if (lock_run + 4'd1 == LOCK_TGT) begin
                        state  <= S_LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     lock_run <= '0;
                  end
               end
               S_LOCKED: begin
                  if (good) begin
                     if (q_in == '0)
                        tc_pulse <= 1'b1;
                     if (q_prev == '0 && q_in == Q_MAX && wrap_cnt != CNT_MAX)
                        wrap_cnt <= wrap_cnt + CNT_W'(1);
                  end else begin
                     state   <= S_FAULT;
                     locked  <= 1'b0;
                     err     <= 1'b1;
                     bad_val <= q_in;
                     if (err_cnt != CNT_MAX)
                        err_cnt <= err_cnt + CNT_W'(1);
                  end
               end
               S_FAULT: begin
                  if (!good) begin
                     bad_val <= q_in;
                     if (err_cnt != CNT_MAX)
                        err_cnt <= err_cnt + CNT_W'(1);
                  end
               end
               default: state <= S_INIT;
            endcase
         end
      end
   end

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
Sits directly downstream of the 3-bit synchronous down counter and consumes its Q bus every clock. It checks that the count decrements by exactly 1 modulo 2^WIDTH, declares lock after a run of good steps and emits a terminal-count pulse. It also counts wrap-arounds and latches sequencing faults for the status/debug path.

Parameters:
WIDTH, 3, width of monitored count bus
LOCK_LEN, 4, consecutive good steps required to enter LOCKED (1..15)
CNT_W, 8, width of wrap_cnt and err_cnt (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately
en  input  1  sample qualifier; 0 = ignore q_in, hold all state
q_in  input  WIDTH  count value from upstream down counter
clr_err  input  1  synchronous clear of err, err_cnt, bad_val; forces re-lock
locked  output  1  high while FSM in LOCKED
tc_pulse  output  1  one-cycle pulse, count reached 0 while LOCKED
wrap_cnt  output  CNT_W  number of 0 -> max transitions seen while LOCKED
err  output  1  sticky fault flag
err_cnt  output  CNT_W  number of bad steps seen while LOCKED or FAULT
bad_val  output  WIDTH  q_in value of most recent bad step

Behaviour:
- Reset (reset=0): state=INIT, q_prev=0, lock_run=0, all outputs 0. Async assert, release takes effect at next rising edge.
- All outputs registered; response visible the cycle after the sampled edge (1-cycle latency).
- en=0: no state, counter or output change, except tc_pulse forced 0 next cycle.
- expected = (q_prev - 1) mod 2^WIDTH; good step = (q_in == expected). q_prev <= q_in on every en=1 edge in every state.
- INIT: first en=1 sample only loads q_prev; -> LOCKING, lock_run=0.
- LOCKING: good step -> lock_run+1; when lock_run reaches LOCK_LEN -> LOCKED, locked=1. Bad step -> lock_run=0, stay LOCKING; not counted in err_cnt.
- LOCKED: good step with q_in==0 -> tc_pulse=1 for exactly one cycle. Good step with q_prev==0 and q_in==2^WIDTH-1 -> wrap_cnt+1. Bad step -> FAULT, err=1, err_cnt+1, bad_val<=q_in, locked=0.
- FAULT: err stays 1; each further bad step -> err_cnt+1, bad_val<=q_in; good steps change nothing else; no tc_pulse, no wrap counting. Exit only via clr_err or reset.
- clr_err=1 (sampled at edge, any state, en ignored): err=0, err_cnt=0, bad_val=0, lock_run=0, state -> LOCKING (INIT stays INIT). clr_err has priority over a simultaneous bad step, which is not counted. wrap_cnt is not cleared.
- Counters saturate at 2^CNT_W-1; no wrap.
- Stalled counter (q_in == q_prev with en=1) is a bad step.
- Reset mid-operation: immediate return to INIT values regardless of state; a subsequent sequence re-locks from scratch.

Test Plan:
- Reset held 0 then released, counter runs 0,7,6,5,4,3,... with en=1 -> locked=1 the cycle after sample 4 (4 good steps), err=0, err_cnt=0.
- Locked, run through 1,0,7 -> tc_pulse=1 exactly one cycle after sample 0; wrap_cnt 0 -> 1 one cycle after sample 7.
- Locked at q=5, inject q_in=2 (expected 4) -> err=1, locked=0, err_cnt=1, bad_val=3'b010; further steps 1,0 are good, err stays 1, err_cnt stays 1.
- In FAULT, pulse clr_err with a simultaneous bad step -> err=0, err_cnt=0, bad_val=0, state LOCKING; locked returns 4 good steps later.
- en=0 for 3 cycles while q_in changes arbitrarily -> no state/counter change, tc_pulse=0; resume en=1 with correct next value -> still locked, no error.
- Assert reset=0 mid-cycle while LOCKED with wrap_cnt=3 -> locked, wrap_cnt, err, err_cnt drop to 0 immediately, without waiting for a clk edge; CNT_W=2 variant with 5 faults -> err_cnt saturates at 3.
